// File: rtl/seg_scan_mux_pkg.sv
// Shared helpers for the display scanner: divider derivation, counter widths, one-hot encode.
// Pure constants and functions; no timing or flow-control behaviour of its own.
package seg_scan_mux_pkg;

  localparam int MAX_DIGITS = 32;

  function automatic int tick_div_f(input int clk_hz, input int scan_hz);
    return clk_hz / scan_hz;
  endfunction

  function automatic int blink_div_f(input int clk_hz, input int blink_hz);
    return clk_hz / (2 * blink_hz);
  endfunction

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [MAX_DIGITS-1:0] one_hot(input int unsigned i);
    return {{(MAX_DIGITS-1){1'b0}}, 1'b1} << i;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Modulo-N free-running counter with a same-cycle wrap flag (count == N-1).
// Latency: wrap is combinational from count; no backpressure, counts every cycle.
module scan_tick_gen
  import seg_scan_mux_pkg::*;
#(
  parameter int N = 10,
  localparam int W = cnt_width(N)
) (
  input  logic         clk,
  input  logic         rst,
  output logic [W-1:0] count,
  output logic         wrap
);

  assign wrap = (count == W'(N - 1));

  always_ff @(posedge clk) begin
    if (rst || wrap) count <= '0;
    else             count <= count + W'(1);
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Seven-segment digit scanner with frame snapshot, inter-slot blanking and blink.
// Outputs registered, 1 cycle after state; no backpressure, scans continuously.
module seg_scan_mux
  import seg_scan_mux_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int SCAN_HZ      = 1000,
  parameter int NUM_DIGITS   = 8,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_HZ     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [3:0]              digit_code,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    dp_out,
  output logic                    frame_start
);

  localparam int TICK_DIV  = tick_div_f(CLK_HZ, SCAN_HZ);
  localparam int BLINK_DIV = blink_div_f(CLK_HZ, BLINK_HZ);
  localparam int CW        = cnt_width(TICK_DIV);
  localparam int IW        = cnt_width(NUM_DIGITS);
  localparam int BW        = cnt_width(BLINK_DIV);

  generate
    if (BLANK_CYCLES < 0 || BLANK_CYCLES >= TICK_DIV) begin : g_bad_blank
      $error("seg_scan_mux: BLANK_CYCLES must satisfy 0 <= BLANK_CYCLES < TICK_DIV");
    end
    if (NUM_DIGITS < 2 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_digits
      $error("seg_scan_mux: NUM_DIGITS out of range");
    end
  endgenerate

  logic [CW-1:0]           cnt;
  logic                    slot_wrap;
  logic [BW-1:0]           bcnt;
  logic                    blink_wrap;
  logic                    unused_bcnt;
  logic [IW-1:0]           idx;
  logic                    bph;
  logic                    frame_now;
  logic [4*NUM_DIGITS-1:0] digits_snap;
  logic [NUM_DIGITS-1:0]   dp_snap;
  logic [NUM_DIGITS-1:0]   blank_snap;
  logic [NUM_DIGITS-1:0]   blink_snap;
  logic                    dark;
  logic                    lit;
  logic [NUM_DIGITS-1:0]   idx_hot;

  scan_tick_gen #(.N(TICK_DIV)) u_slot_tick (
    .clk   (clk),
    .rst   (rst),
    .count (cnt),
    .wrap  (slot_wrap)
  );

  scan_tick_gen #(.N(BLINK_DIV)) u_blink_tick (
    .clk   (clk),
    .rst   (rst),
    .count (bcnt),
    .wrap  (blink_wrap)
  );

  // Blink phase only needs the wrap; the raw count has no other consumer.
  assign unused_bcnt = ^bcnt;

  always_ff @(posedge clk) begin
    if (rst)            idx <= '0;
    else if (slot_wrap) idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)             bph <= 1'b0;
    else if (blink_wrap) bph <= ~bph;
  end

  assign frame_now = (cnt == '0) && (idx == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      digits_snap <= '0;
      dp_snap     <= '0;
      blank_snap  <= '0;
      blink_snap  <= '0;
    end else if (frame_now) begin
      digits_snap <= digits_in;
      dp_snap     <= dp_in;
      blank_snap  <= blank_mask;
      blink_snap  <= blink_mask;
    end
  end

  assign dark    = blank_snap[idx] | (blink_snap[idx] & bph);
  assign lit     = (cnt >= CW'(BLANK_CYCLES)) && !dark;
  assign idx_hot = NUM_DIGITS'(one_hot(32'(idx)));

  always_ff @(posedge clk) begin
    if (rst) begin
      digit_code  <= '0;
      digit_en    <= '0;
      dp_out      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      digit_code  <= digits_snap[{idx, 2'b00} +: 4];
      digit_en    <= lit ? idx_hot : '0;
      dp_out      <= lit & dp_snap[idx];
      frame_start <= frame_now;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Randomized bench for seg_scan_mux against a cycle-index arithmetic model,
// plus literal expectations for scan order, tearing, blank/dp, blink and reset.
module tb_seg_scan_mux;

  localparam int CLK_HZ = 1000;
  localparam int SCAN_HZ = 100;
  localparam int ND = 4;
  localparam int BLANK = 2;
  localparam int BLINK_HZ = 5;
  localparam int TICK = CLK_HZ / SCAN_HZ;
  localparam int BLINK = CLK_HZ / (2 * BLINK_HZ);
  localparam int FRAME = TICK * ND;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits_in = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  blank_mask = 4'h0;
  logic [3:0]  blink_mask = 4'h0;
  logic [3:0]  digit_code;
  logic [3:0]  digit_en;
  logic        dp_out;
  logic        frame_start;

  int n_cmp = 0;
  int n_bad = 0;

  seg_scan_mux #(
    .CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .NUM_DIGITS(ND),
    .BLANK_CYCLES(BLANK), .BLINK_HZ(BLINK_HZ)
  ) dut (
    .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in),
    .blank_mask(blank_mask), .blink_mask(blink_mask),
    .digit_code(digit_code), .digit_en(digit_en), .dp_out(dp_out),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (time %0t)", nm, act, exp, $time);
    end
  endtask

  // Model: everything follows from t = edges since reset release and the
  // inputs latched at the most recent frame-start edge.
  int unsigned t = 0;
  logic [15:0] m_dig = '0;
  logic [3:0]  m_dp = '0, m_blank = '0, m_blink = '0;
  logic [3:0]  e_code = '0, e_en = '0;
  logic        e_dp = 1'b0, e_fs = 1'b0;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    int unsigned c, i;
    bit ph, on;
    if (rst) begin
      t <= 0;
      m_dig <= '0; m_dp <= '0; m_blank <= '0; m_blink <= '0;
      e_code <= '0; e_en <= '0; e_dp <= 1'b0; e_fs <= 1'b0;
      m_valid <= 1'b1;
    end else begin
      c  = t % TICK;
      i  = (t / TICK) % ND;
      ph = ((t / BLINK) % 2) == 1;
      on = (c >= BLANK) && !(m_blank[i] || (m_blink[i] && ph));
      e_code <= m_dig[4*i +: 4];
      e_en   <= on ? 4'(1 << i) : 4'b0;
      e_dp   <= on && m_dp[i];
      e_fs   <= (t % FRAME) == 0;
      if ((t % FRAME) == 0) begin
        m_dig <= digits_in; m_dp <= dp_in; m_blank <= blank_mask; m_blink <= blink_mask;
      end
      t <= t + 1;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("code", digit_code, e_code);
      chk("en", digit_en, e_en);
      chk("dp", dp_out, e_dp);
      chk("frame_start", frame_start, e_fs);
      chk("onehot", ($countones(digit_en) <= 1), 1);
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int nfs;
    digits_in = 16'h4321; blink_mask = 4'b0001;
    repeat (3) step();
    rst = 1'b0;

    // Scan order, tearing and blink on the first run after reset.
    nfs = 0;
    for (int c = 0; c < 240; c++) begin
      if (c == 15) digits_in = 16'h9876;
      step();
      if (frame_start) nfs++;
      case (c)
        0:   begin chk("lit_fs0", frame_start, 1); chk("lit_code0", digit_code, 0); end
        1:   begin chk("lit_code1", digit_code, 1); chk("lit_en1", digit_en, 0); chk("lit_fs1", frame_start, 0); end
        2:   chk("lit_en2", digit_en, 4'b0001);
        10:  begin chk("lit_code10", digit_code, 2); chk("lit_en10", digit_en, 0); end
        12:  chk("lit_en12", digit_en, 4'b0010);
        25:  begin chk("lit_tear25", digit_code, 3); chk("lit_en25", digit_en, 4'b0100); end
        35:  begin chk("lit_tear35", digit_code, 4); chk("lit_en35", digit_en, 4'b1000); end
        40:  begin chk("lit_fs40", frame_start, 1); chk("lit_code40", digit_code, 1); end
        41:  chk("lit_new41", digit_code, 6);
        51:  chk("lit_new51", digit_code, 7);
        125: chk("lit_blink125", digit_en, 0);
        132: chk("lit_blink132", digit_en, 4'b0010);
        165: chk("lit_blink165", digit_en, 0);
        205: chk("lit_blink205", digit_en, 4'b0001);
        default: ;
      endcase
    end
    chk("lit_fs_count_a", nfs, 6);

    // Mid-scan reset, then blank and decimal point.
    repeat (3) step();
    rst = 1'b1;
    blank_mask = 4'b0100; dp_in = 4'b0010; blink_mask = 4'b0000; digits_in = 16'h5A3C;
    step();
    chk("lit_rst_en", digit_en, 0);
    chk("lit_rst_code", digit_code, 0);
    chk("lit_rst_fs", frame_start, 0);
    chk("lit_rst_dp", dp_out, 0);
    repeat (2) step();
    rst = 1'b0;
    nfs = 0;
    for (int c = 0; c < 90; c++) begin
      step();
      if (frame_start) nfs++;
      case (c)
        0:  chk("lit_fs_r0", frame_start, 1);
        5:  begin chk("lit_en_r5", digit_en, 4'b0001); chk("lit_dp_r5", dp_out, 0); end
        11: chk("lit_dp_r11", dp_out, 0);
        15: begin chk("lit_en_r15", digit_en, 4'b0010); chk("lit_dp_r15", dp_out, 1); end
        25: begin chk("lit_blank_r25", digit_en, 0); chk("lit_code_r25", digit_code, 4'hA); end
        40: chk("lit_fs_r40", frame_start, 1);
        80: chk("lit_fs_r80", frame_start, 1);
        default: ;
      endcase
    end
    chk("lit_fs_count_b", nfs, 3);

    // Random inputs and occasional resets.
    for (int k = 0; k < 2500; k++) begin
      if (!rst && $urandom_range(0, 299) == 0) rst = 1'b1;
      else if (rst && $urandom_range(0, 2) == 0) rst = 1'b0;
      if ($urandom_range(0, 7) == 0) digits_in = 16'($urandom());
      if ($urandom_range(0, 15) == 0) dp_in = 4'($urandom());
      if ($urandom_range(0, 31) == 0) blank_mask = 4'($urandom());
      if ($urandom_range(0, 31) == 0) blink_mask = 4'($urandom());
      step();
    end
    rst = 1'b0;
    repeat (50) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
